// File: rtl/npc_pkg.sv
// npc_pkg: shared decode constants, FSM state, ALU op and immediate-format
// enums, the decoded-instruction struct and the immediate generator used by
// the multi-cycle RV32I-subset core.
package npc_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    logic      legal;
    logic      wr_en;
    logic      use_rs1;
    logic      use_rs2;
    logic      use_imm;
    logic      a_pc;      // ALU operand A is pc (AUIPC)
    logic      is_jal;
    logic      is_jalr;
    logic      is_br;
    logic      is_ebreak;
    imm_type_e imm_type;
    alu_op_e   alu_op;
  } dec_t;

  // 32-bit sign-extended immediate; the core widens it to XLEN.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_type_e t);
    logic [31:0] r;
    case (t)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_multicycle_core_if.sv
// npc_multicycle_core_if: instruction-fetch port of the core.
//  req_valid/req_ready : fetch request handshake, addr = fetch address
//  rsp_valid/rsp_data  : instruction word return (one outstanding request max)
// master = core side, slave = instruction memory side.
interface npc_multicycle_core_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;

  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/npc_regfile.sv
// npc_regfile: architectural register file.
//  clk, rst      : clock, synchronous active-high reset (clears all registers)
//  ra1/ra2       : async read addresses -> rd1/rd2
//  we/wa/wd      : synchronous write port
// x0 and indices >= NR_REGS read as zero and are never written.
module npc_regfile #(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  localparam int AW = $clog2(NR_REGS);

  logic [XLEN-1:0] regs [NR_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0 && int'(wa) < NR_REGS) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0 && int'(ra1) < NR_REGS) rd1 = regs[ra1[AW-1:0]];
    if (ra2 != 5'd0 && int'(ra2) < NR_REGS) rd2 = regs[ra2[AW-1:0]];
  end
endmodule

// File: rtl/npc_multicycle_core.sv
// npc_multicycle_core: multi-cycle RV32I-subset core, FETCH -> WAIT -> EXEC.
//  clk, rst     : clock, synchronous active-high reset
//  imem         : fetch port (master modport)
//  commit_*     : one-cycle retire pulse with pc / instruction word
//  pc           : architectural pc
//  halted       : sticky stop; halt_trap: stop was a trap, not ebreak
//  halt_code    : x10 at the moment of halting
module npc_multicycle_core
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NR_REGS  = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic                   clk,
  input  logic                   rst,
  npc_multicycle_core_if.master  imem,
  output logic                   commit_valid,
  output logic [XLEN-1:0]        commit_pc,
  output logic [31:0]            commit_inst,
  output logic [XLEN-1:0]        pc,
  output logic                   halted,
  output logic                   halt_trap,
  output logic [XLEN-1:0]        halt_code
);
  state_e          state;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] a0_q;     // shadow of x10 so halt_code needs no extra read port

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign f3     = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign f7     = inst_q[31:25];

  dec_t dec;
  always_comb begin
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.imm_type = IMM_I;
    case (opcode)
      OP_LUI: begin
        dec.legal = 1'b1; dec.wr_en = 1'b1; dec.use_imm = 1'b1;
        dec.imm_type = IMM_U; dec.alu_op = ALU_PASS;
      end
      OP_AUIPC: begin
        dec.legal = 1'b1; dec.wr_en = 1'b1; dec.use_imm = 1'b1;
        dec.a_pc = 1'b1; dec.imm_type = IMM_U;
      end
      OP_IMM: begin
        dec.wr_en = 1'b1; dec.use_rs1 = 1'b1; dec.use_imm = 1'b1;
        dec.legal = 1'b1;
        case (f3)
          F3_ADD:  dec.alu_op = ALU_ADD;
          F3_SLT:  dec.alu_op = ALU_SLT;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          default: dec.legal  = 1'b0;
        endcase
      end
      OP_REG: begin
        dec.wr_en = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
        dec.legal = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD}: dec.alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD}: dec.alu_op = ALU_SUB;
          {F7_BASE, F3_SLT}: dec.alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}: dec.alu_op = ALU_XOR;
          {F7_BASE, F3_OR }: dec.alu_op = ALU_OR;
          {F7_BASE, F3_AND}: dec.alu_op = ALU_AND;
          default:           dec.legal  = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec.legal = 1'b1; dec.wr_en = 1'b1; dec.is_jal = 1'b1; dec.imm_type = IMM_J;
      end
      OP_JALR: begin
        dec.legal = (f3 == 3'b000); dec.wr_en = 1'b1; dec.use_rs1 = 1'b1;
        dec.is_jalr = 1'b1;
      end
      OP_BR: begin
        dec.legal = (f3 == F3_BEQ) || (f3 == F3_BNE);
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.is_br = 1'b1; dec.imm_type = IMM_B;
      end
      OP_SYS: begin
        dec.legal = (inst_q == INST_EBREAK); dec.is_ebreak = 1'b1;
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] rs1_v, rs2_v, imm, op_a, op_b, alu_res, pc4, target, next_pc, wdata;
  logic            idx_bad, br_taken, redirect, misaligned, trap, rf_we;

  // RV32E-style configs: any referenced register beyond NR_REGS is illegal.
  assign idx_bad = (dec.wr_en   && int'(rd)  >= NR_REGS) ||
                   (dec.use_rs1 && int'(rs1) >= NR_REGS) ||
                   (dec.use_rs2 && int'(rs2) >= NR_REGS);

  assign imm  = XLEN'($signed(imm_gen(inst_q, dec.imm_type)));
  assign op_a = dec.a_pc ? pc : rs1_v;
  assign op_b = dec.use_imm ? imm : rs2_v;

  always_comb begin
    alu_res = '0;
    case (dec.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_PASS: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  assign pc4        = pc + XLEN'(4);
  assign br_taken   = dec.is_br && ((f3 == F3_BEQ) ? (rs1_v == rs2_v) : (rs1_v != rs2_v));
  assign target     = dec.is_jalr ? ((rs1_v + imm) & ~XLEN'(1)) : (pc + imm);
  assign redirect   = dec.is_jal || dec.is_jalr || br_taken;
  assign misaligned = redirect && target[1];
  assign trap       = !dec.legal || idx_bad || misaligned;
  assign next_pc    = dec.is_ebreak ? pc : (redirect ? target : pc4);
  assign wdata      = (dec.is_jal || dec.is_jalr) ? pc4 : alu_res;
  assign rf_we      = (state == EXEC) && !trap && dec.wr_en;

  npc_regfile #(.XLEN(XLEN), .NR_REGS(NR_REGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_v),
    .rd2 (rs2_v),
    .we  (rf_we),
    .wa  (rd),
    .wd  (wdata)
  );

  // Fetch/commit outputs are decoded straight from state/pc/inst_q flops.
  assign imem.req_valid = (state == FETCH);
  assign imem.addr      = pc;
  assign commit_valid   = (state == EXEC) && !trap;
  assign commit_pc      = pc;
  assign commit_inst    = inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      inst_q    <= '0;
      a0_q      <= '0;
      halted    <= 1'b0;
      halt_trap <= 1'b0;
      halt_code <= '0;
    end else begin
      case (state)
        FETCH: if (imem.req_ready) state <= WAIT;
        WAIT: begin
          if (imem.rsp_valid) begin
            inst_q <= imem.rsp_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (trap) begin
            state     <= HALT;
            halted    <= 1'b1;
            halt_trap <= 1'b1;
            halt_code <= a0_q;
          end else begin
            pc <= next_pc;
            if (rf_we && rd == 5'd10) a0_q <= wdata;
            if (dec.is_ebreak) begin
              state     <= HALT;
              halted    <= 1'b1;
              halt_code <= a0_q;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: ;  // HALT is absorbing until reset
      endcase
    end
  end
endmodule

// File: tb/tb_npc_multicycle_core.sv
module tb_npc_multicycle_core;
  localparam logic [31:0] RST_PC = 32'h80000000;
  localparam logic [31:0] I_LW   = 32'h00002003;
  localparam logic [31:0] I_EBRK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid, halted, halt_trap;
  logic [31:0] commit_pc, commit_inst, pc, halt_code;

  always #5 clk = ~clk;

  npc_multicycle_core_if #(.XLEN(32)) imem();

  npc_multicycle_core #(.XLEN(32), .NR_REGS(32), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .pc           (pc),
    .halted       (halted),
    .halt_trap    (halt_trap),
    .halt_code    (halt_code)
  );

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [64];
  int checks = 0, errors = 0, commit_cnt = 0;
  int ncyc = 0, stall_until = 0, rsp_dly = 0, acc_cnt = 0;

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - RST_PC) >> 2;
    if (idx < 64) return mem[idx[5:0]];
    return I_LW;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = I_LW;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back('{pc: p, inst: i});
  endtask

  task automatic do_reset(input int stall, input int dly);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    stall_until = ncyc + stall;
    rsp_dly     = dly;
    rst         = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin cyc(); n++; end
    if (halted !== 1'b1) begin
      checks++; errors++;
      $display("FAIL halt_timeout: got halted=%b expected 1 within %0d cycles", halted, budget);
    end
  endtask

  task automatic wait_commit(input int base, input int budget);
    int n = 0;
    while (commit_cnt == base && n < budget) begin cyc(); n++; end
    if (commit_cnt == base) begin
      checks++; errors++;
      $display("FAIL commit_timeout: got no commit expected one within %0d cycles", budget);
    end
  endtask

  // Instruction memory: one outstanding request, response rsp_dly cycles
  // after the one-cycle best case. Inputs change on negedges only.
  bit          pend = 1'b0;
  int          dly  = 0;
  logic [31:0] pend_data = '0;
  initial begin
    imem.req_ready = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      imem.rsp_valid = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          imem.rsp_valid = 1'b1;
          imem.rsp_data  = pend_data;
          pend = 1'b0;
        end else dly--;
      end
      imem.req_ready = (ncyc > stall_until) && !pend;
      if (!rst && imem.req_valid === 1'b1 && imem.req_ready) begin
        pend      = 1'b1;
        dly       = rsp_dly;
        pend_data = fetch_word(imem.addr);
        acc_cnt++;
      end
    end
  end

  // Commit monitor / scoreboard.
  exp_t e_mon;
  initial begin
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        commit_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got pc %08h inst %08h expected none", commit_pc, commit_inst);
        end else begin
          e_mon = exp_q.pop_front();
          chk("commit_pc", commit_pc, e_mon.pc);
          chk("commit_inst", commit_inst, e_mon.inst);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int n, c0, a0, bad;

    // 1/2: reset state, first-commit latency, arithmetic sequence
    clear_mem();
    mem[0] = 32'h00500093;  // addi x1,x0,5
    mem[1] = 32'hFF908113;  // addi x2,x1,-7
    mem[2] = 32'h402081B3;  // sub  x3,x1,x2
    mem[3] = I_EBRK;
    push(RST_PC,      32'h00500093);
    push(RST_PC + 4,  32'hFF908113);
    push(RST_PC + 8,  32'h402081B3);
    push(RST_PC + 12, I_EBRK);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc", pc, RST_PC);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_trap", {31'b0, halt_trap}, 32'd0);
    chk("rst_code", halt_code, 32'd0);
    chk("rst_commit", {31'b0, commit_valid}, 32'd0);
    stall_until = ncyc;
    rsp_dly     = 0;
    rst         = 1'b0;
    chk("rst_addr", imem.addr, RST_PC);
    chk("rst_req", {31'b0, imem.req_valid}, 32'd1);
    n = 0;
    while (commit_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("first_commit_latency", n, 32'd3);
    wait_halt(100);
    chk("t2_x1", dut.u_rf.regs[1], 32'd5);
    chk("t2_x2", dut.u_rf.regs[2], 32'hFFFFFFFE);
    chk("t2_x3", dut.u_rf.regs[3], 32'd7);
    chk("t2_trap", {31'b0, halt_trap}, 32'd0);
    chk("t2_pc", pc, RST_PC + 12);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: ebreak halt with code, no further fetches
    clear_mem();
    mem[0] = 32'h02A00513;  // addi x10,x0,42
    mem[1] = I_EBRK;
    push(RST_PC, 32'h02A00513);
    push(RST_PC + 4, I_EBRK);
    c0 = commit_cnt;
    do_reset(0, 0);
    wait_halt(50);
    chk("t3_trap", {31'b0, halt_trap}, 32'd0);
    chk("t3_code", halt_code, 32'd42);
    n = 0;
    repeat (20) begin cyc(); if (imem.req_valid !== 1'b0) n++; end
    chk("t3_no_req", n, 32'd0);
    chk("t3_commits", commit_cnt - c0, 32'd2);
    chk("t3_pc", pc, RST_PC + 4);

    // 4: request stall and slow response
    clear_mem();
    mem[0] = 32'h00300293;  // addi x5,x0,3
    mem[1] = I_EBRK;
    push(RST_PC, 32'h00300293);
    push(RST_PC + 4, I_EBRK);
    c0 = commit_cnt;
    do_reset(5, 3);
    bad = 0;
    repeat (5) begin
      cyc();
      if (imem.req_valid !== 1'b1 || imem.addr !== RST_PC || imem.req_ready !== 1'b0) bad++;
    end
    chk("t4_addr_stable", bad, 32'd0);
    wait_commit(c0, 40);
    repeat (4) cyc();
    chk("t4_one_commit", commit_cnt - c0, 32'd1);
    wait_halt(50);
    chk("t4_commits", commit_cnt - c0, 32'd2);
    chk("t4_x5", dut.u_rf.regs[5], 32'd3);

    // 5: jal and not-taken bne
    clear_mem();
    mem[0] = 32'h008000EF;  // jal x1,+8
    mem[1] = I_LW;          // skipped
    mem[2] = 32'h00001463;  // bne x0,x0,+8
    mem[3] = 32'h00100513;  // addi x10,x0,1
    mem[4] = I_EBRK;
    push(RST_PC,      32'h008000EF);
    push(RST_PC + 8,  32'h00001463);
    push(RST_PC + 12, 32'h00100513);
    push(RST_PC + 16, I_EBRK);
    c0 = commit_cnt;
    do_reset(0, 0);
    wait_commit(c0, 20);
    cyc();
    chk("t5_next_fetch", imem.addr, RST_PC + 8);
    wait_halt(50);
    chk("t5_x1", dut.u_rf.regs[1], RST_PC + 4);
    chk("t5_code", halt_code, 32'd1);
    chk("t5_trap", {31'b0, halt_trap}, 32'd0);
    chk("t5_pc", pc, RST_PC + 16);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: illegal load traps without commit
    clear_mem();
    c0 = commit_cnt;
    do_reset(0, 0);
    wait_halt(50);
    chk("t6_trap", {31'b0, halt_trap}, 32'd1);
    chk("t6_no_commit", commit_cnt - c0, 32'd0);
    chk("t6_pc", pc, RST_PC);

    // 6b: reset while waiting; the stale (illegal) response must be ignored
    clear_mem();
    a0 = acc_cnt;
    do_reset(0, 2);
    cyc();
    chk("t6b_accept", acc_cnt - a0, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    stall_until = ncyc + 4;
    mem[0] = 32'h00900513;  // addi x10,x0,9
    mem[1] = I_EBRK;
    push(RST_PC, 32'h00900513);
    push(RST_PC + 4, I_EBRK);
    c0 = commit_cnt;
    @(posedge clk); #2 rst = 1'b0;
    wait_halt(60);
    chk("t6b_trap", {31'b0, halt_trap}, 32'd0);
    chk("t6b_code", halt_code, 32'd9);
    chk("t6b_commits", commit_cnt - c0, 32'd2);
    chk("t6b_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
